// File: rtl/entry_buffer.sv
// First-word fall-through entry buffer between fetch and its consumer, with
// almost-full backpressure. Define ENTRY_BUFFER_OVF_EN to add the sticky ovf flag.
module entry_buffer #(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 1,
  parameter int ENTRY_W      = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [ENTRY_W-1:0]     in_entry,
  output logic                   full,
  output logic                   out_valid,
  output logic [ENTRY_W-1:0]     out_entry,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
`ifdef ENTRY_BUFFER_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CAP_LVL   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic               w_at_cap;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic [CW-1:0]      w_count_nxt;

  assign w_at_cap = (r_count == CAP_LVL);
  assign w_pop    = en & out_valid & out_ready;
  // A pop at capacity frees the slot the same-cycle push writes into.
  assign w_push   = en & in_valid & (~w_at_cap | w_pop);
  assign w_drop   = en & in_valid & w_at_cap & ~w_pop;

  always_comb begin
    // NOTE: default first so every path assigns w_count_nxt; no latch inferred.
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone says which
  // slots hold live data.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_entry;
  end

`ifdef ENTRY_BUFFER_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (reset)       r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`else
  logic w_drop_unused;
  assign w_drop_unused = w_drop;
`endif

  assign count     = r_count;
  assign empty     = (r_count == '0);
  assign out_valid = ~empty;
  assign full      = (r_count >= AFULL_LVL);
  assign out_entry = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_entry_buffer.sv
// Directed bench for entry_buffer (DEPTH=8, AFULL_MARGIN=1): table of vectors
// plus hand-written fill/wrap/reset sequences checked against a queue model.
module tb_entry_buffer;

  localparam int DEPTH = 8;
  localparam int EW    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          in_valid;
  logic [EW-1:0] in_entry;
  logic          full;
  logic          out_valid;
  logic [EW-1:0] out_entry;
  logic          out_ready;
  logic [3:0]    count;
  logic          empty;
`ifdef ENTRY_BUFFER_OVF_EN
  logic          ovf;
`endif

  entry_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(1), .ENTRY_W(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_entry  (in_entry),
    .full      (full),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .out_ready (out_ready),
    .count     (count),
    .empty     (empty)
`ifdef ENTRY_BUFFER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          en;
    logic          in_valid;
    logic [EW-1:0] in_entry;
    logic          out_ready;
    int            exp_count;
    logic          exp_full;
    logic [EW-1:0] exp_entry;
    logic          chk_entry;
  } vec_t;

  vec_t vecs[16];
  logic [EW-1:0] model_q[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_entry = '0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(logic e, logic v, logic [EW-1:0] d, logic r,
                              int c, logic f, logic [EW-1:0] x, logic ce);
    vec_t t;
    t.en = e; t.in_valid = v; t.in_entry = d; t.out_ready = r;
    t.exp_count = c; t.exp_full = f; t.exp_entry = x; t.chk_entry = ce;
    return t;
  endfunction

  initial begin
    logic [EW-1:0] ea, eb, ec, ed;
    ea = 64'h0102030405060708;
    eb = 64'h1111_2222_3333_4444;
    ec = 64'hDEAD_BEEF_CAFE_F00D;
    ed = 64'h5555_AAAA_5555_AAAA;

    vecs[0]  = mk(1, 1, ea, 0, 1, 0, ea, 1);
    vecs[1]  = mk(1, 1, eb, 0, 2, 0, ea, 1);
    vecs[2]  = mk(1, 1, ec, 0, 3, 0, ea, 1);
    for (int i = 3; i < 7; i++)  vecs[i] = mk(0, 1, ed, 1, 3, 0, ea, 1);
    for (int i = 7; i < 12; i++) vecs[i] = mk(1, 0, ed, 0, 3, 0, ea, 1);
    vecs[12] = mk(1, 0, '0, 1, 2, 0, eb, 1);
    vecs[13] = mk(1, 0, '0, 1, 1, 0, ec, 1);
    vecs[14] = mk(1, 0, '0, 1, 0, 0, '0, 0);
    vecs[15] = mk(1, 0, '0, 1, 0, 0, '0, 0);

    // Reset state
    do_reset();
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full), 64'd0);
`ifdef ENTRY_BUFFER_OVF_EN
    check("rst_ovf",   64'(ovf), 64'd0);
`endif

    // Table: push, en-low hold, out_ready-low hold, drain, pop-when-empty
    for (int i = 0; i < 16; i++) begin
      en = vecs[i].en; in_valid = vecs[i].in_valid;
      in_entry = vecs[i].in_entry; out_ready = vecs[i].out_ready;
      step();
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_count != 0));
      check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].exp_count == 0));
      check($sformatf("vec%0d_full", i),  64'(full), 64'(vecs[i].exp_full));
      if (vecs[i].chk_entry)
        check($sformatf("vec%0d_entry", i), out_entry, vecs[i].exp_entry);
    end

    // Fill to capacity, almost-full threshold, then a dropped push
    do_reset();
    model_q.delete();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      in_entry = 64'hA000 + 64'(k);
      if (k <= DEPTH) model_q.push_back(in_entry);
      step();
      check($sformatf("fill%0d_count", k), 64'(count), 64'((k > DEPTH) ? DEPTH : k));
      check($sformatf("fill%0d_full", k),  64'(full), 64'(k >= DEPTH - 1));
    end
    check("drop_head", out_entry, model_q[0]);
`ifdef ENTRY_BUFFER_OVF_EN
    check("drop_ovf", 64'(ovf), 64'd1);
`endif

    // Simultaneous push and pop at capacity across pointer wrap
    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_entry = 64'hB000 + 64'(j);
      void'(model_q.pop_front());
      model_q.push_back(in_entry);
      step();
      check($sformatf("wrap%0d_entry", j), out_entry, model_q[0]);
      check($sformatf("wrap%0d_count", j), 64'(count), 64'(DEPTH));
    end

    // Reset mid-operation with count=5, in_valid held high through reset
    do_reset();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_entry = 64'hC000 + 64'(k);
      step();
    end
    check("pre_rst_count", 64'(count), 64'd5);
    reset = 1'b1;
    in_entry = 64'hEEEE;
    step();
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_full",  64'(full), 64'd0);
`ifdef ENTRY_BUFFER_OVF_EN
    check("mid_rst_ovf",   64'(ovf), 64'd0);
`endif
    reset = 1'b0;
    in_entry = 64'h0F0F_0F0F_0F0F_0F0F;
    step();
    in_valid = 1'b0;
    check("first_push_count", 64'(count), 64'd1);
    check("first_push_entry", out_entry, 64'h0F0F_0F0F_0F0F_0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/entry_buffer.md
ENTRY_BUFFER -- requirements
Module: entry_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of TABLE_ENTRY slots; power of two, minimum 2.
REQ-002 Parameter AFULL_MARGIN, default 1, free slots still left when full asserts; range 0..DEPTH-1.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  stage enable; when low, no push and no pop take effect.
REQ-006 in_valid  input  1  push request; driven by fetch ob_valid.
REQ-007 in_entry  input  TABLE_ENTRY  entry to store; driven by fetch entry.
REQ-008 full  output  1  backpressure to fetch; drives fetch ob_full.
REQ-009 out_valid  output  1  head entry available to the downstream consumer.
REQ-010 out_entry  output  TABLE_ENTRY  head entry, first-word fall-through.
REQ-011 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 empty  output  1  high when count == 0.

Function
REQ-014 Circular storage of DEPTH entries; read and write pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-015 push = en & in_valid & (count < DEPTH | pop); pop = en & out_valid & out_ready.
REQ-016 Accepted push writes in_entry at the write pointer at posedge; the entry is visible on out_entry/out_valid in the next cycle (1-cycle latency); no same-cycle bypass.
REQ-017 out_valid = !empty; out_entry is the slot at the read pointer, driven from registers only, with no combinational path from in_* to out_*.
REQ-018 out_entry is don't-care while out_valid is low; out_entry is stable while out_valid is high and out_ready is low.
REQ-019 full = (count >= DEPTH - AFULL_MARGIN), registered-state derived; margin absorbs fetch's one-cycle ob_full reaction.
REQ-020 Simultaneous push and pop: count unchanged, both pointers advance; legal at count == DEPTH (pop frees the slot in the same cycle).
REQ-021 Push with count == DEPTH and no pop: entry dropped, pointers and count unchanged.
REQ-022 Pop when empty: ignored (impossible, since out_valid is low).
REQ-023 count never exceeds DEPTH and never underflows below 0.
REQ-024 en low: pointers, count and storage hold; outputs reflect held state.

Reset
REQ-025 While reset is high at posedge: read/write pointers = 0, count = 0; out_valid = 0, empty = 1, full = 0 (for AFULL_MARGIN < DEPTH).
REQ-026 Reset mid-operation discards all stored entries; storage contents are not cleared; in_valid during reset is ignored.
REQ-027 First push is accepted in the first cycle with reset low.

Configuration
REQ-028 Macro ENTRY_BUFFER_OVF_EN defined: extra output ovf (1 bit), reset 0, set sticky on any push dropped per REQ-021, cleared only by reset.
REQ-029 ENTRY_BUFFER_OVF_EN undefined: ovf port and logic are absent; dropped pushes are silent; all other behaviour is identical.

Verification (DEPTH=8, AFULL_MARGIN=1)
REQ-030 Reset, then one push of 64'h0102030405060708 with out_ready=0 -> next cycle out_valid=1, out_entry=0102030405060708, count=1, empty=0.
REQ-031 Seven pushes with no pops -> full=1 after the 7th (count=7); 8th push while full=1 is accepted -> count=8; 9th push dropped, count=8, ovf=1 when the macro is defined.
REQ-032 Fill 8 entries, then 20 cycles of push and pop together with out_ready=1 -> count stays 8, output order matches input order across pointer wrap.
REQ-033 Hold out_ready=0 for 5 cycles with 3 entries stored -> out_entry stable and count=3; then out_ready=1 -> three entries drain in order, empty=1.
REQ-034 en=0 with in_valid=1 and out_ready=1 for 4 cycles -> count, out_entry and pointers unchanged.
REQ-035 Reset asserted with count=5 -> next cycle count=0, out_valid=0, full=0, ovf=0.
